uart_hex_feeder: RTL and testbench

Formatter stage placed directly upstream of the UART transmitter. Captured bytes (for example, RGMII frame octets) are buffered in a small FIFO. Each byte is rendered as two ASCII hex characters followed by a separator. Characters are handed one at a time to the transmitter through its DV/Active/Done handshake, turning a raw byte stream into a readable line-oriented hex dump.

---
 rtl/uart_hex_feeder.sv | 151 +++++++++++++++
 tb/tb_uart_hex_feeder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_feeder.sv
// Byte FIFO + hex-dump formatter feeding a UART transmitter over its DV/Active/Done handshake.
// Define UART_HEX_LOWERCASE_EN to emit hex letters as a-f instead of A-F.
module uart_hex_feeder #(
    parameter int FIFO_DEPTH     = 16,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic                          i_Data_Valid,
    input  logic [7:0]                    i_Data,
    input  logic                          i_Data_Last,
    output logic                          o_Data_Ready,
    output logic                          o_TX_DV,
    output logic [7:0]                    o_TX_Byte,
    input  logic                          i_TX_Active,
    input  logic                          i_TX_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Level,
    output logic                          o_Busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(BYTES_PER_LINE) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK, S_WAIT} state_t;
    typedef enum logic [2:0] {C_HI, C_LO, C_SP, C_CR, C_LF} sel_t;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full, empty, push, pop;

    state_t        state_q, state_d;
    sel_t          sel_q, sel_d;
    logic [8:0]    hold_q, hold_d;
    logic [LW-1:0] line_q, line_d;
    logic          dv_q, dv_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    cur_char;
    logic          tx_idle;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return {4'h3, n};
`ifdef UART_HEX_LOWERCASE_EN
        return 8'h57 + {4'h0, n};
`else
        return 8'h37 + {4'h0, n};
`endif
    endfunction

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = i_Data_Valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    assign o_Data_Ready = !full;
    assign o_Fifo_Level = wr_ptr_q - rd_ptr_q;
    assign o_Busy       = !empty || (state_q != S_IDLE);
    assign o_TX_DV      = dv_q;
    assign o_TX_Byte    = byte_q;

    // Done must also be low: the transmitter is still in its cleanup cycle while Done is high.
    assign tx_idle = !i_TX_Active && !i_TX_Done;

    always_ff @(posedge i_Clock) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= {i_Data_Last, i_Data};
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sel_q    <= C_HI;
            hold_q   <= '0;
            line_q   <= '0;
            dv_q     <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
            line_q   <= line_d;
            dv_q     <= dv_d;
            byte_q   <= byte_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_ISSUE;
            S_ISSUE: if (tx_idle) state_d = S_ACK;
            S_ACK:   if (i_TX_Active) state_d = S_WAIT;
            S_WAIT:  if (i_TX_Done)
                         state_d = (sel_q == C_SP || sel_q == C_LF) ? S_IDLE : S_ISSUE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (sel_q)
            C_HI:    cur_char = hex_char(hold_q[7:4]);
            C_LO:    cur_char = hex_char(hold_q[3:0]);
            C_CR:    cur_char = 8'h0D;
            C_LF:    cur_char = 8'h0A;
            default: cur_char = 8'h20;
        endcase
    end

    always_comb begin
        sel_d  = sel_q;
        hold_d = hold_q;
        line_d = line_q;
        dv_d   = 1'b0;
        byte_d = byte_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    hold_d = mem_q[rd_ptr_q[AW-1:0]];
                    sel_d  = C_HI;
                end
            end
            S_ISSUE: begin
                if (tx_idle) begin
                    dv_d   = 1'b1;
                    byte_d = cur_char;
                end
            end
            S_WAIT: begin
                if (i_TX_Done) begin
                    case (sel_q)
                        C_HI: sel_d = C_LO;
                        // line_q counts bytes already finished on this line
                        C_LO: sel_d = (hold_q[8] || line_q == LW'(BYTES_PER_LINE - 1)) ? C_CR : C_SP;
                        C_CR: sel_d = C_LF;
                        C_SP: line_d = line_q + LW'(1);
                        C_LF: line_d = '0;
                        default: sel_d = C_HI;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_hex_feeder.sv
// Scoreboard bench for uart_hex_feeder with a behavioural UART transmitter (10 bit times, 2-cycle Done).
module tb_uart_hex_feeder;
    localparam int DEPTH = 16;
    localparam int BPL   = 16;
    localparam int LIMIT = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_Data_Valid = 1'b0;
    logic [7:0] i_Data = 8'h00;
    logic       i_Data_Last = 1'b0;
    logic       o_Data_Ready, o_TX_DV, o_Busy;
    logic [7:0] o_TX_Byte;
    logic [$clog2(DEPTH):0] o_Fifo_Level;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;

    always #5 clk = ~clk;

    uart_hex_feeder #(.FIFO_DEPTH(DEPTH), .BYTES_PER_LINE(BPL)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_Data_Valid(i_Data_Valid), .i_Data(i_Data), .i_Data_Last(i_Data_Last),
        .o_Data_Ready(o_Data_Ready), .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
        .i_TX_Active(tx_active), .i_TX_Done(tx_done),
        .o_Fifo_Level(o_Fifo_Level), .o_Busy(o_Busy)
    );

    // Transmitter model; not reset, so a started character runs to completion.
    int cpb = 4;
    int tx_cnt = 0;
    int tx_phase = 0;
    always @(posedge clk) begin
        case (tx_phase)
            0: begin
                tx_done <= 1'b0;
                if (o_TX_DV) begin
                    tx_active <= 1'b1;
                    tx_cnt    <= 10 * cpb - 1;
                    tx_phase  <= 1;
                end
            end
            1: begin
                if (tx_cnt == 0) begin
                    tx_active <= 1'b0;
                    tx_done   <= 1'b1;
                    tx_phase  <= 2;
                end else
                    tx_cnt <= tx_cnt - 1;
            end
            default: begin
                tx_done  <= 1'b1;
                tx_phase <= 0;
            end
        endcase
    end

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];
    int model_line = 0;
    int dv_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input int n);
        if (n < 10) return 8'(48 + n);
`ifdef UART_HEX_LOWERCASE_EN
        return 8'(97 + n - 10);
`else
        return 8'(65 + n - 10);
`endif
    endfunction

    task automatic model_push(input logic [7:0] d, input logic last);
        exp_q.push_back(hexc(int'(d[7:4])));
        exp_q.push_back(hexc(int'(d[3:0])));
        if (last || model_line == BPL - 1) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            model_line = 0;
        end else begin
            exp_q.push_back(8'h20);
            model_line++;
        end
    endtask

    // Monitor: every DV pops one expected character.
    initial begin
        logic prev_dv;
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (o_TX_DV) begin
                dv_seen++;
                check("dv_width", prev_dv, 0);
                check("dv_while_tx_busy", {tx_active, tx_done}, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_char: got %02h expected none", o_TX_Byte);
                end else
                    check("char", o_TX_Byte, exp_q.pop_front());
            end
            prev_dv = o_TX_DV;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        i_Data_Valid = 1'b1;
        i_Data = d;
        i_Data_Last = l;
        while (!o_Data_Ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            fails++;
            $display("FAIL push_timeout: got ready=0 expected ready=1");
        end
        model_push(d, l);
        @(negedge clk);
        i_Data_Valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_Busy || tx_active || tx_done) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_in_time"}, n < LIMIT, 1);
        check({name, "_busy_end"}, o_Busy, 0);
        check({name, "_level_end"}, o_Fifo_Level, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_dv", o_TX_DV, 0);
        check("rst_byte", o_TX_Byte, 8'h00);
        check("rst_ready", o_Data_Ready, 1);
        check("rst_level", o_Fifo_Level, 0);
        check("rst_busy", o_Busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_dv", o_TX_DV, 0);
            check("idle_ready", o_Data_Ready, 1);
            check("idle_level", o_Fifo_Level, 0);
        end

        // Single byte: first DV exactly two edges after the push edge.
        push_byte(8'hA5, 1'b0);
        n = 0;
        while (!o_TX_DV && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("first_dv_latency", n, 2);
        wait_drain("a5");

        push_byte(8'h3C, 1'b1);
        wait_drain("3c");

        for (int b = 0; b <= 16; b++)
            push_byte(8'(b), 1'b0);
        wait_drain("line");

        // Back-to-back burst into a slow transmitter.
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            i_Data_Valid = 1'b1;
            i_Data = 8'($urandom_range(0, 255));
            i_Data_Last = 1'b0;
            check("burst_ready", o_Data_Ready, 1);
            model_push(i_Data, 1'b0);
            @(negedge clk);
        end
        i_Data_Valid = 1'b0;
        check("full_ready", o_Data_Ready, 0);
        check("full_level", o_Fifo_Level, 16);
        wait_drain("burst");

        for (int batch = 0; batch < 3; batch++) begin
            cpb = int'($urandom_range(1, 6));
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
            end
            wait_drain("random");
        end

        // Reset in WAIT with bytes queued; transmitter keeps running.
        cpb = 12;
        for (int i = 0; i < 6; i++)
            push_byte(8'($urandom_range(0, 255)), 1'b0);
        n = 0;
        while ((dv_seen == 0 || !tx_active) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (dv_seen == 0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("pre_reset_tx_active", tx_active, 1);
        check("pre_reset_level", o_Fifo_Level, 5);
        rst_n = 1'b0;
        exp_q.delete();
        model_line = 0;
        @(negedge clk);
        check("mid_rst_level", o_Fifo_Level, 0);
        check("mid_rst_ready", o_Data_Ready, 1);
        check("mid_rst_dv", o_TX_DV, 0);
        check("mid_rst_busy", o_Busy, 0);
        check("mid_rst_byte", o_TX_Byte, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_byte(8'h5A, 1'b0);
        check("post_rst_tx_still_busy", tx_active, 1);
        wait_drain("post_rst");
        repeat (50) @(negedge clk);
        check("post_rst_no_extra", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #50ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
